// File: rtl/cpu_pkg.sv
// Shared definitions for the minimal 8-bit arithmetic CPU core.
//
// Contents:
//   - DATA_W / OP_W : fixed data and opcode widths
//   - OP_*          : 2-bit opcode encodings
//   - FLAG_*        : bit positions inside the 4-bit flags register {dz, v, c, z}
//   - cpu_flags_t   : packed view of the flags register, for checkers and benches
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_MUL = 2'b10;
  localparam logic [OP_W-1:0] OP_DIV = 2'b11;

  localparam int FLAG_W  = 4;
  localparam int FLAG_Z  = 0;
  localparam int FLAG_C  = 1;
  localparam int FLAG_V  = 2;
  localparam int FLAG_DZ = 3;

  // Same bit order as the flags register: [3]=dz [2]=v [1]=c [0]=z.
  typedef struct packed {
    logic dz;
    logic v;
    logic c;
    logic z;
  } cpu_flags_t;

endpackage

// File: rtl/cpu_alu.sv
// Purely combinational ALU for the cpu core.
//
// Ports:
//   op [1:0]  in  : operation select (OP_ADD / OP_SUB / OP_MUL / OP_DIV)
//   a  [7:0]  in  : first operand
//   b  [7:0]  in  : second operand
//   y  [7:0]  out : 8-bit result
//   c         out : ADD carry-out, SUB borrow, MUL high-byte-nonzero, DIV always 0
//   v         out : signed overflow for ADD/SUB, 0 otherwise
//   dz        out : divide by zero (DIV with b == 0), 0 otherwise
//
// The multiplier is an unrolled shift-add and the divider an unrolled
// 8-step restoring divider; neither uses the '*' or '/' operators.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              c,
  output logic              v,
  output logic              dz
);

  logic [DATA_W:0]     sum9;
  logic [DATA_W:0]     diff9;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   quotient;

  // Adder and subtractor, each with one extra bit to catch carry / borrow.
  always_comb begin
    sum9  = {1'b0, a} + {1'b0, b};
    diff9 = {1'b0, a} - {1'b0, b};
  end

  // Shift-add multiplier: add b shifted left by i for every set bit a[i].
  always_comb begin
    product = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (a[i]) begin
        product = product + ({{DATA_W{1'b0}}, b} << i);
      end
    end
  end

  // Restoring divider, MSB first. The partial remainder is one bit wider than
  // the divisor so the trial subtraction never loses the shifted-in bit.
  always_comb begin
    logic [DATA_W:0] rem;
    rem      = '0;
    quotient = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      rem = {rem[DATA_W-1:0], a[i]};
      if (rem >= {1'b0, b}) begin
        rem         = rem - {1'b0, b};
        quotient[i] = 1'b1;
      end
    end
  end

  always_comb begin
    y  = '0;
    c  = 1'b0;
    v  = 1'b0;
    dz = 1'b0;
    unique case (op)
      OP_ADD: begin
        y = sum9[DATA_W-1:0];
        c = sum9[DATA_W];
        // Overflow: both operands share a sign that the sum does not.
        v = (a[DATA_W-1] == b[DATA_W-1]) && (sum9[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB: begin
        y = diff9[DATA_W-1:0];
        c = diff9[DATA_W];
        // Overflow: operand signs differ and the result sign differs from a.
        v = (a[DATA_W-1] != b[DATA_W-1]) && (diff9[DATA_W-1] != a[DATA_W-1]);
      end
      OP_MUL: begin
        y = product[DATA_W-1:0];
        c = |product[2*DATA_W-1:DATA_W];
      end
      OP_DIV: begin
        if (b == '0) begin
          y  = '1;
          dz = 1'b1;
        end else begin
          y = quotient;
        end
      end
      default: begin
        y = '0;
      end
    endcase
  end

endmodule

// File: rtl/cpu.sv
// Minimal 8-bit arithmetic CPU core: one ALU operation per clock on two
// internal operand registers, result registered.
//
// Ports:
//   clk          in  : single clock, all state updates on the rising edge
//   reset        in  : asynchronous, active-high reset
//   result [7:0] out : registered ALU result (1-cycle latency)
//
// Internal state (names fixed, written by the surrounding environment
// through hierarchy): opcode, operand1, operand2, result, flags {dz, v, c, z}.
// The core itself only clears opcode/operand1/operand2 on reset; between
// resets they keep whatever was last written into them from outside.
// There is no handshake: result is valid from the edge after the operands
// or opcode change.
module cpu
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] result
);

  logic [OP_W-1:0]   opcode;
  logic [DATA_W-1:0] operand1;
  logic [DATA_W-1:0] operand2;
  logic [FLAG_W-1:0] flags;

  logic [DATA_W-1:0] alu_y;
  logic              alu_c;
  logic              alu_v;
  logic              alu_dz;
  logic              next_z;

  cpu_alu u_alu (
    .op (opcode),
    .a  (operand1),
    .b  (operand2),
    .y  (alu_y),
    .c  (alu_c),
    .v  (alu_v),
    .dz (alu_dz)
  );

  // Operand/opcode registers are loaded from outside the module, so this
  // process has only a reset branch; outside reset they simply hold.
  // A plain always block is used because a second writer exists.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode   <= OP_ADD;
      operand1 <= '0;
      operand2 <= '0;
    end
  end

  assign next_z = (alu_y == '0);

  // Result and flags. Reset clears both immediately, discarding any
  // result in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      flags  <= '0;
    end else begin
      result         <= alu_y;
      flags[FLAG_Z]  <= next_z;
      flags[FLAG_C]  <= alu_c;
      flags[FLAG_V]  <= alu_v;
      flags[FLAG_DZ] <= alu_dz;
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: a table of directed vectors with
// hand-computed results/flags, plus reset sequences.
module tb_cpu;

  logic       clk;
  logic       reset;
  logic [7:0] result;

  int checks;
  int errors;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic [3:0] f;  // {dz, v, c, z}
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  cpu dut (
    .clk    (clk),
    .reset  (reset),
    .result (result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%02h) expected %0d (0x%02h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Load operands between edges, let one rising edge execute, sample 1 ns later.
  task automatic apply(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    dut.opcode   = op;
    dut.operand1 = a;
    dut.operand2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] y, input logic [3:0] f);
    vecs[i].op = op;
    vecs[i].a  = a;
    vecs[i].b  = b;
    vecs[i].y  = y;
    vecs[i].f  = f;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //            op     a    b    y    {dz,v,c,z}
    set_vec(0,  2'b00,  40,   5,  45, 4'b0000);  // ADD basic
    set_vec(1,  2'b01,  15,   2,  13, 4'b0000);  // SUB basic
    set_vec(2,  2'b01,   2,  15, 243, 4'b0010);  // SUB borrow
    set_vec(3,  2'b10,   4,   5,  20, 4'b0000);  // MUL basic
    set_vec(4,  2'b10,  20,  20, 144, 4'b0010);  // MUL high byte nonzero
    set_vec(5,  2'b11,  16,   2,   8, 4'b0000);  // DIV basic
    set_vec(6,  2'b11,   7,   0, 255, 4'b1000);  // DIV by zero
    set_vec(7,  2'b00, 100, 100, 200, 4'b0100);  // ADD signed overflow
    set_vec(8,  2'b01,   5,   5,   0, 4'b0001);  // SUB zero
    set_vec(9,  2'b01, 128,   1, 127, 4'b0100);  // SUB signed overflow
    set_vec(10, 2'b10,   0,   9,   0, 4'b0001);  // MUL zero
    set_vec(11, 2'b11, 255,  16,  15, 4'b0000);  // DIV truncation
    set_vec(12, 2'b11,   3,   7,   0, 4'b0001);  // DIV quotient zero
    set_vec(13, 2'b00, 255,   1,   0, 4'b0011);  // ADD wrap to zero
    set_vec(14, 2'b11, 200,   3,  66, 4'b0000);  // DIV 200/3
    set_vec(15, 2'b00, 200, 100,  44, 4'b0010);  // ADD carry, no overflow

    // ---- reset held 20 ns ----
    reset = 1'b1;
    #20;
    check8("reset_result", result, 8'd0);
    check4("reset_flags", dut.flags, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // ---- no write after release: 0+0 ----
    @(posedge clk);
    #1;
    check8("idle_result", result, 8'd0);
    check4("idle_flags", dut.flags, 4'b0001);

    // ---- vector table ----
    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check8($sformatf("vec%0d_result", i), result, vecs[i].y);
      check4($sformatf("vec%0d_flags", i), dut.flags, vecs[i].f);
    end

    // ---- operands hold: a second edge repeats the last operation ----
    @(posedge clk);
    #1;
    check8("hold_result", result, 8'd44);

    // ---- reset asserted between edges clears result at once ----
    @(negedge clk);
    reset = 1'b1;
    #1;
    check8("midreset_result", result, 8'd0);
    check4("midreset_flags", dut.flags, 4'b0000);
    check8("midreset_operand1", dut.operand1, 8'd0);
    check8("midreset_operand2", dut.operand2, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check8("post_reset_result", result, 8'd0);
    check4("post_reset_flags", dut.flags, 4'b0001);

    // ---- operation straight after reset ----
    apply(2'b10, 8'd15, 8'd17);  // 255, fits in 8 bits
    check8("post_reset_mul", result, 8'd255);
    check4("post_reset_mul_flags", dut.flags, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
